maf_conv_scheduler: RTL and testbench

Round-robin scheduler that shares one `Multiply_AccumulateConversion` datapath (C ± A·B, FP↔int conversion on C) among `NUM_REQ` requesters. It registers the granted operands onto the MAF inputs and tracks each operation through the MAF's fixed pipeline latency. Each result is captured into a credit-protected result FIFO and returned with its requester tag. The block sits between the client ports and the MAF instance.

---
 rtl/maf_sched_pkg.sv | 23 ++
 rtl/maf_result_fifo.sv | 62 ++++++
 rtl/maf_conv_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_maf_conv_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_sched_pkg.sv
// Shared definitions for the MAF scheduler: conversion and exception-field codes plus a clog2 helper.
package maf_sched_pkg;

    localparam logic [1:0] FP_operation = 2'd0;
    localparam logic [1:0] FP_to_int    = 2'd1;
    localparam logic [1:0] int_to_FP    = 2'd2;

    // Top two operand bits encode the number class.
    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/maf_result_fifo.sv
// Result FIFO: push lands in storage at the clock edge, the head is visible the cycle after.
// Push and pop may coincide at any occupancy; the head reads as zero while empty.
module maf_result_fifo
    import maf_sched_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/maf_conv_scheduler.sv
// Round-robin front end sharing one MAF among NUM_REQ clients; request-to-result latency LATENCY+2.
// Credits cap accepted-but-unpopped work at FIFO_DEPTH, so a stalled consumer stops new grants.
module maf_conv_scheduler
    import maf_sched_pkg::*;
#(
    parameter int size       = 34,
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = 2,
    parameter int LATENCY    = 0,
    parameter int FIFO_DEPTH = LATENCY + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_conversion,
    input  logic [NUM_REQ-1:0]      req_sub,
    input  logic [size*NUM_REQ-1:0] req_a,
    input  logic [size*NUM_REQ-1:0] req_b,
    input  logic [size*NUM_REQ-1:0] req_c,
    output logic                    maf_valid,
    output logic [1:0]              maf_conversion,
    output logic                    maf_sub,
    output logic [size-1:0]         maf_a,
    output logic [size-1:0]         maf_b,
    output logic [size-1:0]         maf_c,
    input  logic [size-1:0]         maf_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [size-1:0]         res_number,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    idle
);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             maf_valid_q, maf_valid_d;
    logic [TAG_W-1:0] maf_tag_q, maf_tag_d;
    logic [1:0]       maf_conv_q, maf_conv_d;
    logic             maf_sub_q, maf_sub_d;
    logic [size-1:0]  maf_a_q, maf_a_d, maf_b_q, maf_b_d, maf_c_q, maf_c_d;

    logic [TAG_W-1:0] cand, grant_idx;
    logic             grant_any, issue_ok, accept, pop;
    logic [1:0]       sel_conv;
    logic             sel_sub;
    logic [size-1:0]  sel_a, sel_b, sel_c;
    logic             cap_vld;
    logic [TAG_W-1:0] cap_tag;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [TAG_W+size-1:0] fifo_head;

    // Scan from lowest to highest priority so the last hit (ptr+1 side) wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = TAG_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_conv = '0;
        sel_sub  = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        sel_c    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == TAG_W'(i)) begin
                sel_conv = req_conversion[2*i +: 2];
                sel_sub  = req_sub[i];
                sel_a    = req_a[size*i +: size];
                sel_b    = req_b[size*i +: size];
                sel_c    = req_c[size*i +: size];
            end
        end
    end

    // A pop in this cycle frees the slot the new accept will need.
    always_comb begin
        pop         = res_valid & res_ready;
        issue_ok    = (credits_q < CW'(FIFO_DEPTH)) | ((credits_q == CW'(FIFO_DEPTH)) & pop);
        accept      = grant_any & issue_ok & ~rst;
        req_ready   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
        credits_d   = credits_q + CW'(accept) - CW'(pop);
        ptr_d       = accept ? grant_idx : ptr_q;
        maf_valid_d = accept;
        maf_tag_d   = accept ? grant_idx : maf_tag_q;
        maf_conv_d  = accept ? sel_conv  : maf_conv_q;
        maf_sub_d   = accept ? sel_sub   : maf_sub_q;
        maf_a_d     = accept ? sel_a     : maf_a_q;
        maf_b_d     = accept ? sel_b     : maf_b_q;
        maf_c_d     = accept ? sel_c     : maf_c_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= TAG_W'(NUM_REQ - 1);
            credits_q   <= '0;
            maf_valid_q <= 1'b0;
            maf_tag_q   <= '0;
            maf_conv_q  <= '0;
            maf_sub_q   <= 1'b0;
            maf_a_q     <= '0;
            maf_b_q     <= '0;
            maf_c_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            credits_q   <= credits_d;
            maf_valid_q <= maf_valid_d;
            maf_tag_q   <= maf_tag_d;
            maf_conv_q  <= maf_conv_d;
            maf_sub_q   <= maf_sub_d;
            maf_a_q     <= maf_a_d;
            maf_b_q     <= maf_b_d;
            maf_c_q     <= maf_c_d;
        end
    end

    // Valid/tag shadow of the MAF pipeline, qualifying when maf_result belongs to us.
    if (LATENCY == 0) begin : g_no_pipe
        assign cap_vld = maf_valid_q;
        assign cap_tag = maf_tag_q;
    end else begin : g_pipe
        logic [LATENCY-1:0] pv_q, pv_d;
        logic [TAG_W-1:0]   pt_q [LATENCY];
        logic [TAG_W-1:0]   pt_d [LATENCY];

        always_comb begin
            pv_d[0] = maf_valid_q;
            pt_d[0] = maf_tag_q;
            for (int i = 1; i < LATENCY; i++) begin
                pv_d[i] = pv_q[i-1];
                pt_d[i] = pt_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q <= '0;
                for (int i = 0; i < LATENCY; i++) begin
                    pt_q[i] <= '0;
                end
            end else begin
                pv_q <= pv_d;
                pt_q <= pt_d;
            end
        end

        assign cap_vld = pv_q[LATENCY-1];
        assign cap_tag = pt_q[LATENCY-1];
    end

    maf_result_fifo #(
        .WIDTH (TAG_W + size),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_vld),
        .push_data ({cap_tag, maf_result}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_fifo_within_credits: assert property (@(posedge clk) disable iff (rst) fifo_count <= credits_q);

    assign res_valid      = ~fifo_empty;
    assign {res_tag, res_number} = fifo_head;
    assign idle           = (credits_q == '0);
    assign maf_valid      = maf_valid_q;
    assign maf_conversion = maf_conv_q;
    assign maf_sub        = maf_sub_q;
    assign maf_a          = maf_a_q;
    assign maf_b          = maf_b_q;
    assign maf_c          = maf_c_q;

endmodule

// File: tb/tb_maf_conv_scheduler.sv
// Bench for maf_conv_scheduler with a behavioural MAF stand-in and an arbitration/result scoreboard.
module tb_maf_conv_scheduler;
    localparam int SIZE  = 34;
    localparam int N     = 4;
    localparam int TW    = 2;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid, req_ready, req_sub;
    logic [2*N-1:0]    req_conversion;
    logic [SIZE*N-1:0] req_a, req_b, req_c;
    logic              maf_valid, maf_sub;
    logic [1:0]        maf_conversion;
    logic [SIZE-1:0]   maf_a, maf_b, maf_c, maf_result;
    logic              res_valid, res_ready, idle;
    logic [SIZE-1:0]   res_number;
    logic [TW-1:0]     res_tag;

    logic [1:0]      tb_cv [N];
    logic            tb_s  [N];
    logic [SIZE-1:0] tb_a  [N];
    logic [SIZE-1:0] tb_b  [N];
    logic [SIZE-1:0] tb_c  [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [TW-1:0]   tag;
        logic [SIZE-1:0] num;
        int              due;
    } exp_t;
    exp_t sb[$];
    exp_t m_item;
    int   ptr_m = N - 1;
    int   credits_m = 0;
    int   m_g;
    bit   m_rv, m_pop;
    logic [TW-1:0] m_idx;
    logic [N-1:0]  m_rdy;

    always #5 clk = ~clk;

    maf_conv_scheduler #(
        .size(SIZE), .NUM_REQ(N), .TAG_W(TW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_conversion(req_conversion),
        .req_sub(req_sub), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .maf_valid(maf_valid), .maf_conversion(maf_conversion), .maf_sub(maf_sub),
        .maf_a(maf_a), .maf_b(maf_b), .maf_c(maf_c), .maf_result(maf_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_number(res_number),
        .res_tag(res_tag), .idle(idle)
    );

    // Stand-in MAF: exact for the 1.0 + 1.0*2.0 case, a deterministic mix otherwise.
    function automatic logic [SIZE-1:0] maf_fn(input logic [1:0] cv, input logic s,
                                               input logic [SIZE-1:0] a, b, c);
        if (cv == 2'd0 && !s && a == 34'h13F800000 && b == 34'h140000000 && c == 34'h13F800000)
            return 34'h140400000;
        return a ^ {b[16:0], b[33:17]} ^ (c + 34'd7) ^ {cv, s, 31'd0};
    endfunction

    logic [SIZE-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= maf_fn(maf_conversion, maf_sub, maf_a, maf_b, maf_c);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign maf_result = mpipe[LAT-1];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_conversion[2*i +: 2] = tb_cv[i];
            req_sub[i]               = tb_s[i];
            req_a[SIZE*i +: SIZE]    = tb_a[i];
            req_b[SIZE*i +: SIZE]    = tb_b[i];
            req_c[SIZE*i +: SIZE]    = tb_c[i];
        end
    end

    function automatic logic [SIZE-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[SIZE-1:0];
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] cv, input logic s,
                           input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] c);
        req_valid[i] = v;
        tb_cv[i] = cv;
        tb_s[i]  = s;
        tb_a[i]  = a;
        tb_b[i]  = b;
        tb_c[i]  = c;
    endtask

    task automatic rand_all();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 2'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), rnd(), rnd(), rnd());
    endtask

    task automatic drain(output bit ok);
        req_valid = '0;
        res_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (idle === 1'b1 && res_valid === 1'b0) ok = 1'b1;
        end
    endtask

    // Scoreboard: independent arbiter/credit model; expected results queued on accept.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb.delete();
            ptr_m = N - 1;
            credits_m = 0;
        end else begin
            m_rv  = (sb.size() > 0) && (sb[0].due <= cyc);
            m_pop = m_rv && (res_ready === 1'b1);
            checks++;
            if (res_valid !== m_rv) begin
                errors++;
                $display("FAIL mon_res_valid cyc=%0d: got %b expected %b", cyc, res_valid, m_rv);
            end
            checks++;
            if (idle !== (credits_m == 0)) begin
                errors++;
                $display("FAIL mon_idle cyc=%0d: got %b expected %b", cyc, idle, credits_m == 0);
            end
            if (m_pop) begin
                checks++;
                if (res_tag !== sb[0].tag || res_number !== sb[0].num) begin
                    errors++;
                    $display("FAIL mon_result cyc=%0d: got tag %0d num %h expected tag %0d num %h",
                             cyc, res_tag, res_number, sb[0].tag, sb[0].num);
                end
                void'(sb.pop_front());
            end
            m_g = -1;
            for (int k = N; k >= 1; k--) begin
                m_idx = TW'((ptr_m + k) % N);
                if (req_valid[m_idx]) m_g = (ptr_m + k) % N;
            end
            m_rdy = '0;
            if (m_g >= 0 && (credits_m < DEPTH || (credits_m == DEPTH && m_pop)))
                m_rdy = N'(1) << m_g;
            checks++;
            if (req_ready !== m_rdy) begin
                errors++;
                $display("FAIL mon_req_ready cyc=%0d: got %b expected %b", cyc, req_ready, m_rdy);
            end
            if (m_rdy != '0) begin
                m_item.tag = TW'(m_g);
                m_item.num = maf_fn(tb_cv[m_g], tb_s[m_g], tb_a[m_g], tb_b[m_g], tb_c[m_g]);
                m_item.due = cyc + LAT + 2;
                sb.push_back(m_item);
                ptr_m = m_g;
                credits_m++;
            end
            if (m_pop) credits_m--;
        end
        cyc++;
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (req_ready !== '0)      begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        checks++; if (maf_valid !== 1'b0)    begin errors++; $display("FAIL rst_maf_valid: got %b expected 0", maf_valid); end
        checks++; if (maf_conversion !== '0) begin errors++; $display("FAIL rst_maf_conv: got %0d expected 0", maf_conversion); end
        checks++; if (maf_sub !== 1'b0)      begin errors++; $display("FAIL rst_maf_sub: got %b expected 0", maf_sub); end
        checks++; if ({maf_a, maf_b, maf_c} !== '0) begin errors++; $display("FAIL rst_maf_ops: got %h %h %h expected 0", maf_a, maf_b, maf_c); end
        checks++; if (res_valid !== 1'b0)    begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_number !== '0)     begin errors++; $display("FAIL rst_res_number: got %h expected 0", res_number); end
        checks++; if (res_tag !== '0)        begin errors++; $display("FAIL rst_res_tag: got %0d expected 0", res_tag); end
        checks++; if (idle !== 1'b1)         begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        set_req(2, 1'b1, 2'd0, 1'b0, 34'h13F800000, 34'h140000000, 34'h13F800000);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (maf_valid !== 1'b1) begin errors++; $display("FAIL single_maf_valid: got %b expected 1", maf_valid); end
        checks++;
        if (maf_a !== 34'h13F800000 || maf_b !== 34'h140000000 || maf_c !== 34'h13F800000 || maf_conversion !== 2'd0) begin
            errors++;
            $display("FAIL single_maf_ops: got a=%h b=%h c=%h cv=%0d", maf_a, maf_b, maf_c, maf_conversion);
        end
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_%0d: got res_valid %b expected 0", k, res_valid); end
        end
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_tag !== 2'd2 || res_number !== 34'h140400000) begin
            errors++;
            $display("FAIL single_result: got v=%b tag=%0d num=%h expected v=1 tag=2 num=140400000",
                     res_valid, res_tag, res_number);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: got busy expected idle"); end
    endtask

    task automatic test_conversion();
        bit ok;
        logic [SIZE-1:0] a, b;
        a = rnd();
        b = rnd();
        @(negedge clk);
        set_req(1, 1'b1, 2'd2, 1'b0, a, b, 34'h1_0000_0005);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conv_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (maf_valid !== 1'b1 || maf_conversion !== 2'd2 || maf_c !== 34'h1_0000_0005) begin
            errors++;
            $display("FAIL conv_maf: got v=%b cv=%0d c=%h expected v=1 cv=2 c=100000005", maf_valid, maf_conversion, maf_c);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_tag !== 2'd1 || res_number !== maf_fn(2'd2, 1'b0, a, b, 34'h1_0000_0005)) begin
            errors++;
            $display("FAIL conv_result: got v=%b tag=%0d num=%h expected v=1 tag=1 num=%h",
                     res_valid, res_tag, res_number, maf_fn(2'd2, 1'b0, a, b, 34'h1_0000_0005));
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL conv_drain: got busy expected idle"); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [N-1:0] exp_g;
        @(negedge clk);
        res_ready = 1'b1;
        set_req(3, 1'b1, 2'd0, 1'b0, rnd(), rnd(), rnd());
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_park: got %b expected 1000", req_ready); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rand_all();
            exp_g = N'(1) << (c % N);
            #1;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", c, req_ready, exp_g); end
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_drain: got busy expected idle"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            res_ready = 1'b0;
            rand_all();
            #1;
            if (req_ready !== '0) acc++;
            if (c >= DEPTH) begin
                checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall_%0d: got %b expected 0", c, req_ready); end
            end
        end
        checks++; if (acc != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", acc, DEPTH); end
        @(negedge clk);
        res_ready = 1'b1;
        rand_all();
        #1;
        checks++;
        if (res_valid !== 1'b1 || !$onehot(req_ready)) begin
            errors++;
            $display("FAIL bp_pop_accept: got res_valid=%b req_ready=%b expected 1 and one-hot", res_valid, req_ready);
        end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL bp_still_full: got req_ready=%b idle=%b expected 0 0", req_ready, idle);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got busy expected idle"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int first, nres, nwin;
        first = -1;
        nres  = 0;
        nwin  = 0;
        for (int c = 0; c < 108; c++) begin
            @(negedge clk);
            res_ready = 1'b1;
            if (c < 100) rand_all();
            else req_valid = '0;
            #1;
            if (c < 100) begin
                checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL b2b_gap_%0d: got %b expected one-hot", c, req_ready); end
            end
            if (res_valid === 1'b1) begin
                nres++;
                if (first < 0) first = c;
                if (c >= LAT + 2 && c < LAT + 102) nwin++;
            end
        end
        checks++; if (first != LAT + 2) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", first, LAT + 2); end
        checks++; if (nres != 100 || nwin != 100) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 100/100", nres, nwin); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got busy expected idle"); end
    endtask

    task automatic test_reset_mid();
        int nres;
        nres = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            res_ready = 1'b1;
            rand_all();
        end
        @(negedge clk);
        rand_all();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || maf_valid !== 1'b0 || res_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_ctrl: got ready=%b maf_v=%b res_v=%b idle=%b expected 0 0 0 1",
                     req_ready, maf_valid, res_valid, idle);
        end
        checks++;
        if ({maf_conversion, maf_sub, maf_a, maf_b, maf_c, res_number, res_tag} !== '0) begin
            errors++;
            $display("FAIL mid_rst_data: got maf_a=%h maf_c=%h res=%h expected 0", maf_a, maf_c, res_number);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rand_all();
        #1;
        checks++;
        if (req_ready !== 4'b0001 || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_grant: got ready=%b idle=%b expected 0001 1", req_ready, idle);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (res_valid === 1'b1) nres++;
        end
        checks++; if (nres != 1) begin errors++; $display("FAIL mid_stale: got %0d results expected 1", nres); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_end: got %b expected 1", idle); end
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'd0, 1'b0, '0, '0, '0);
        test_reset();
        test_single();
        test_conversion();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
